mdu_seq: RTL
============

# mdu_seq

Iterative multiply/divide unit for the multicycle CPU. It decodes the R-type `funct` field for MULT/MULTU/DIV/DIVU/MTHI/MTLO and computes results over multiple cycles using a shift-add multiplier or a restoring divider. Results go into architectural HI/LO registers. The main FSM drives it with a start/busy/done handshake, and reads MFHI/MFLO directly from the `hi`/`lo` outputs.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be at least 4.
- `CNTW`, default 6: iteration counter width; must satisfy 2^CNTW > WIDTH.

Clock and reset:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.

Command inputs:
- `start`, in, 1: command strobe; sampled only in IDLE.
- `funct`, in, 6: R-type function code.
- `a`, in, WIDTH: rs operand (dividend / multiplicand / MTxx source).
- `b`, in, WIDTH: rt operand (divisor / multiplier).

Status and result outputs:
- `busy`, out, 1: high while state is CALC or FIX.
- `done`, out, 1: one-cycle pulse; `hi`/`lo` are valid in this cycle.
- `dbz`, out, 1: divide-by-zero flag; pulses together with `done`.
- `hi`, out, WIDTH: HI register.
- `lo`, out, WIDTH: LO register.

## Operation
**Decoded `funct` codes**
- 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO.
- Any other code with `start` is ignored: state stays IDLE, no `done`.

**Operand capture**
- On accept, `a`, `b` and the opcode are latched.
- Input changes while busy have no effect.

**Signed operations**
- The unit works on magnitudes |a| and |b| (unsigned, WIDTH bits; |min| = 2^(WIDTH-1) fits).
- FIX applies signs:
  - Product sign = a[MSB] ^ b[MSB].
  - Quotient sign = a[MSB] ^ b[MSB].
  - Remainder sign = a[MSB].

**MULT/MULTU**
- Shift-add, one multiplier bit per cycle.
- Uses a 2·WIDTH accumulator: {hi, lo} = full product.

**DIV/DIVU**
- Restoring division, one quotient bit per cycle.
- lo = quotient, hi = remainder.
- DIV of most-negative by −1 gives lo = most-negative, hi = 0, with no flag.

**Divide by zero (b == 0)**
- Same latency as a normal divide.
- lo = all ones, hi = a (raw, unsigned), dbz = 1.

**MTHI/MTLO**
- hi (or lo) ← a at the accept edge.
- `busy` never asserts; `done` pulses in the next cycle.
- The other register is unchanged.

**FSM**
- IDLE: on `start` with MULT/MULTU/DIV/DIVU, go to CALC with counter = 0.
- CALC: counter +1 per cycle; after WIDTH iterations go to FIX.
- FIX: applies signs, writes hi/lo, sets `done`, returns to IDLE.

**Register update rules**
- hi/lo change only in the FIX cycle or on an MTxx accept.
- Intermediate values live in separate work registers, so HI/LO keep their old values while busy.

## Timing
- `start` is accepted at edge T while in IDLE.

**MULT/DIV family (W = WIDTH)**
- `busy` = 1 in cycles T+1 … T+W+1 (W cycles of CALC, then 1 cycle of FIX).
- hi/lo are updated at the edge ending FIX.
- `done` = 1 in cycle T+W+2 (34 cycles after accept for W = 32); `busy` = 0 in that cycle.

**MTxx**
- hi/lo are updated at edge T.
- `done` = 1 in cycle T+1.

**Start handling**
- `start` while busy is ignored: no queueing, no effect on the running operation.
- `start` in a `done` cycle is accepted (the state is IDLE), so back-to-back operations lose no cycle.

**Reset**
- `rst_n` low at any time, including mid-CALC:
  - state = IDLE; hi = lo = 0; busy = done = dbz = 0; work registers cleared.
- The aborted operation produces no `done`.
- After `rst_n` rises, the first edge with `start` may accept a command.

## Test plan
1. Unsigned multiply: MULTU, a = 0xFFFFFFFF, b = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; `done` exactly at T+34; `busy` high 33 cycles.
2. Signed multiply and divide:
   - MULT, a = 0xFFFFFFFD (−3), b = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
   - DIV, a = 0xFFFFFFF9 (−7), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
   - DIVU, a = 7, b = 2 -> lo = 3, hi = 1.
3. Corner divides:
   - DIV, a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0, dbz = 0.
   - DIVU, a = 5, b = 0 -> lo = 0xFFFFFFFF, hi = 5, dbz = 1 with `done`.
4. Move and ignore rules:
   - MTHI, a = 0x1234 -> hi = 0x1234 next cycle, `done` at T+1, lo unchanged, `busy` never high.
   - `start` with funct = 0x20 -> no `done`, no state change.
5. Start-while-busy and back-to-back:
   - During MULTU, pulse `start` with DIVU and change a/b mid-CALC -> original product unaffected.
   - `start` DIVU 100/7 in the `done` cycle -> `done` 34 cycles later with lo = 14, hi = 2.
6. Reset mid-operation: assert `rst_n` = 0 at T+10 of a DIV -> hi = lo = 0 and busy = done = 0 immediately (asynchronous); no `done` after release; a new MULT completes normally.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit with architectural HI/LO.
// Shift-add multiply and restoring divide on magnitudes, signs fixed at the end.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_nxt;

    logic dec_md, dec_div, dec_sgn, dec_mthi, dec_mtlo;
    logic accept_md, accept_mt;

    logic [WIDTH-1:0]   a_q, b_q, ma;
    logic [2*WIDTH-1:0] acc;
    logic [CNTW-1:0]    cnt;
    logic               op_div, op_sgn;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_t, div_r;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt;

    logic               fix_neg, rem_neg, fix_dbz;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

    // Decode the function code into operation class and signedness.
    always_comb begin
        dec_md   = 1'b0;
        dec_div  = 1'b0;
        dec_sgn  = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
        case (funct)
            F_MULT:  begin dec_md = 1'b1; dec_sgn = 1'b1; end
            F_MULTU: begin dec_md = 1'b1; end
            F_DIV:   begin dec_md = 1'b1; dec_div = 1'b1; dec_sgn = 1'b1; end
            F_DIVU:  begin dec_md = 1'b1; dec_div = 1'b1; end
            F_MTHI:  dec_mthi = 1'b1;
            F_MTLO:  dec_mtlo = 1'b1;
            default: ;
        endcase
    end

    assign accept_md = start && (state == IDLE) && dec_md;
    assign accept_mt = start && (state == IDLE) && (dec_mthi || dec_mtlo);
    assign busy      = (state != IDLE);

    assign a_mag = (dec_sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (dec_sgn && b[WIDTH-1]) ? -b : b;

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
        mul_nxt = {mul_sum, acc[WIDTH-1:1]};
        div_t   = acc[2*WIDTH-1:WIDTH-1];
        div_ge  = (div_t >= {1'b0, ma});
        div_r   = div_ge ? (div_t - {1'b0, ma}) : div_t;
        div_nxt = {div_r[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
    end

    // Apply result signs and the divide-by-zero override.
    always_comb begin
        fix_neg = op_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rem_neg = op_sgn & a_q[WIDTH-1];
        fix_dbz = op_div && (b_q == '0);
        prod    = fix_neg ? -acc : acc;
        quo     = acc[WIDTH-1:0];
        rem     = acc[2*WIDTH-1:WIDTH];
        if (fix_neg) quo = -acc[WIDTH-1:0];
        if (rem_neg) rem = -acc[2*WIDTH-1:WIDTH];
        fix_hi  = prod[2*WIDTH-1:WIDTH];
        fix_lo  = prod[WIDTH-1:0];
        if (op_div) begin
            fix_hi = fix_dbz ? a_q : rem;
            fix_lo = fix_dbz ? '1 : quo;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_md) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Work registers: operand capture and iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            ma     <= '0;
            acc    <= '0;
            cnt    <= '0;
            op_div <= 1'b0;
            op_sgn <= 1'b0;
        end else if (accept_md) begin
            a_q    <= a;
            b_q    <= b;
            op_div <= dec_div;
            op_sgn <= dec_sgn;
            cnt    <= '0;
            ma     <= dec_div ? b_mag : a_mag;
            acc    <= {{WIDTH{1'b0}}, (dec_div ? a_mag : b_mag)};
        end else if (state == CALC) begin
            cnt <= cnt + CNTW'(1);
            acc <= op_div ? div_nxt : mul_nxt;
        end
    end

    // Architectural HI/LO and the done/dbz pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
            dbz  <= 1'b0;
        end else begin
            done <= 1'b0;
            dbz  <= 1'b0;
            if (accept_mt) begin
                if (dec_mthi) hi <= a;
                else          lo <= a;
                done <= 1'b1;
            end else if (state == FIX) begin
                hi   <= fix_hi;
                lo   <= fix_lo;
                done <= 1'b1;
                dbz  <= fix_dbz;
            end
        end
    end

endmodule
